mod12_count_monitor: RTL and testbench
======================================

Name: mod12_count_monitor

Overview:
- Observer and checker for the team's 4-bit mod-12 up/down counter with load. It sits on the receiving side of the counter's output bus.
- Each cycle it samples the counter's control inputs and output value, then predicts the value for the next cycle.
- It compares that prediction against the next sample and reports mismatches.
- It also counts wrap-arounds and reports lock and direction status. Used in-system for integrity checking and as a scoreboard in benches.

Parameters:
- MAX_VAL, 11, terminal count of the observed counter (wrap point).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset of the monitor.
- mon_en  input  1  monitor enable; low forces IDLE.
- mon_clr  input  1  synchronous clear of counters and state.
- c_rstn  input  1  observed counter's synchronous active-low reset.
- c_load  input  1  observed counter's load.
- c_mode  input  1  observed counter's mode (0 = up, 1 = down).
- c_data  input  4  observed counter's load data.
- c_dout  input  4  observed counter's output value.
- locked  output  1  high while in TRACK.
- mon_err  output  1  one-cycle pulse on a mismatch.
- range_err  output  1  one-cycle pulse when c_dout > MAX_VAL.
- err_cnt  output  ERR_W  saturating mismatch count.
- wrap_cnt  output  WRAP_W  saturating wrap-event count.
- dir  output  1  c_mode of the last non-load, non-reset sample.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, all outputs 0, expectation register cleared.
- Prediction from the sample at cycle k, applied to the sample at cycle k+1:
  - !c_rstn -> 0.
  - else c_load -> c_data.
  - else up: c_dout==MAX_VAL ? 0 : c_dout+1, 4-bit modulo.
  - else down: c_dout==0 ? MAX_VAL : c_dout-1, 4-bit modulo.
  - Exact 4-bit arithmetic: 15 up -> 0, 14 up -> 15. Out-of-range values are still predicted, not flagged as mismatch.
- FSM IDLE:
  - No comparison is made.
  - If mon_en=1 and mon_clr=0: capture the prediction and go to TRACK.
- FSM TRACK:
  - Each cycle compare c_dout against the stored expectation.
  - On mismatch: mon_err=1 in cycle k+2, where k is the predicting sample. err_cnt increments and saturates at all-ones.
  - The new prediction is always computed from the actual sample, so one corrupted value yields exactly one error (resync).
- TRACK -> IDLE when mon_en=0 or mon_clr=1. Re-entry needs one IDLE sample before comparisons resume.
- mon_clr (synchronous):
  - err_cnt, wrap_cnt, dir, mon_err and range_err are set to 0; state goes to IDLE.
  - mon_clr has priority over a coincident error or wrap.
- Wrap event: a sample with c_rstn=1, c_load=0 and either (up and c_dout==MAX_VAL) or (down and c_dout==0).
  - Counted in TRACK or IDLE→TRACK entry when mon_en=1.
  - wrap_cnt increments the next cycle and saturates.
  - Counted regardless of whether the following sample matches.
- range_err: pulses the cycle after any sample with c_dout > MAX_VAL while mon_en=1, independent of state.
- dir: updated the cycle after any sample with c_rstn=1 and c_load=0 while mon_en=1.
- All outputs are registered. Maximum latency from sample to flag is 1 cycle.
- rstn asserted mid-run: immediate return to reset values. Counters are not preserved.

Optional Feature:
- Macro MOD12_MON_FIRST_ERR_EN adds first-error capture.
- With the macro defined, extra outputs are added:
  - first_exp (4): expected value at the first mismatch since reset/clear.
  - first_act (4): actual value at the first mismatch.
  - first_vld (1): set once a first error is held.
  - Captured on the first mismatch only and held until rstn or mon_clr.
  - Later errors do not overwrite. Reset values are 0.
- Without the macro: these ports and registers do not exist, and the rest of the behaviour is identical.

Test Plan:
- Up-count check: mon_en=1, c_mode=0, c_dout sweeps 0..11,0,1 -> locked=1 after the first sample, mon_err never set, wrap_cnt=1, dir=0.
- Down-count check: c_mode=1, c_dout sweeps 3,2,1,0,11,10 -> no mon_err, wrap_cnt=1, dir=1.
- Load and reset: c_load=1 with c_data=7 and c_dout=2, next c_dout=7; then c_rstn=0 with c_dout=5, next c_dout=0 -> no error, no wrap count, dir unchanged.
- Single fault: up sequence 4,5,9,10 -> exactly one mon_err pulse (for the 9), err_cnt=1; with MOD12_MON_FIRST_ERR_EN, first_exp=6, first_act=9, first_vld=1.
- Saturation and clear: ERR_W=2, inject 5 mismatches -> err_cnt=3. Assert mon_clr together with a 6th mismatch -> err_cnt=0, mon_err=0, locked=0.
- Range and async reset: c_dout=13 up, then 14 -> range_err pulses twice, no mon_err. Drop rstn mid-cycle -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mod12_count_monitor.sv
// mod12_count_monitor: predicts and checks a mod-12 up/down/load counter, counting mismatches and wraps.
// Optional first-error capture (first_exp/first_act/first_vld) is enabled by defining MOD12_MON_FIRST_ERR_EN.
module mod12_count_monitor #(
  parameter int MAX_VAL = 11,
  parameter int ERR_W   = 8,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mon_en,
  input  logic              mon_clr,
  input  logic              c_rstn,
  input  logic              c_load,
  input  logic              c_mode,
  input  logic [3:0]        c_data,
  input  logic [3:0]        c_dout,
  output logic              locked,
  output logic              mon_err,
  output logic              range_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              dir
`ifdef MOD12_MON_FIRST_ERR_EN
  ,
  output logic [3:0]        first_exp,
  output logic [3:0]        first_act,
  output logic              first_vld
`endif
);
  typedef enum logic {IDLE, TRACK} state_t;
  localparam logic [3:0] MAX = 4'(MAX_VAL);
  state_t state, state_nx;
  logic [3:0] exp_val, pred;
  logic run, mismatch, wrap_ev;
  always_comb begin
    run = mon_en && !mon_clr;
    pred = !c_rstn ? 4'd0 :
           c_load  ? c_data :
           !c_mode ? (c_dout == MAX  ? 4'd0 : c_dout + 4'd1) :
                     (c_dout == 4'd0 ? MAX  : c_dout - 4'd1);
    wrap_ev = c_rstn && !c_load && (c_mode ? c_dout == 4'd0 : c_dout == MAX);
    mismatch = run && state == TRACK && c_dout != exp_val;
    state_nx = run ? TRACK : IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  assign locked = state == TRACK;
  // Expectation always follows the actual sample, so one bad value yields one error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_val   <= '0;
      mon_err   <= 1'b0;
      range_err <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
      dir       <= 1'b0;
    end else begin
      if (run) exp_val <= pred;
      mon_err   <= mismatch;
      range_err <= run && c_dout > MAX;
      if (mon_clr) begin
        err_cnt  <= '0;
        wrap_cnt <= '0;
        dir      <= 1'b0;
      end else begin
        if (mismatch && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        if (run && wrap_ev && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + 1'b1;
        if (mon_en && c_rstn && !c_load) dir <= c_mode;
      end
    end
  end
`ifdef MOD12_MON_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_exp <= '0;
      first_act <= '0;
      first_vld <= 1'b0;
    end else if (mon_clr) begin
      first_exp <= '0;
      first_act <= '0;
      first_vld <= 1'b0;
    end else if (mismatch && !first_vld) begin
      first_exp <= exp_val;
      first_act <= c_dout;
      first_vld <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mod12_count_monitor.sv
// tb_mod12_count_monitor: table-driven directed check of mod12_count_monitor (ERR_W=2 to reach saturation).
module tb_mod12_count_monitor;
  logic clk = 1'b0, rstn = 1'b0;
  logic mon_en = 0, mon_clr = 0, c_rstn = 0, c_load = 0, c_mode = 0;
  logic [3:0] c_data = '0, c_dout = '0;
  logic locked, mon_err, range_err, dir;
  logic [1:0] err_cnt;
  logic [7:0] wrap_cnt;
`ifdef MOD12_MON_FIRST_ERR_EN
  logic [3:0] first_exp, first_act;
  logic first_vld;
`endif
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  mod12_count_monitor #(.MAX_VAL(11), .ERR_W(2), .WRAP_W(8)) dut (
    .clk(clk), .rstn(rstn), .mon_en(mon_en), .mon_clr(mon_clr),
    .c_rstn(c_rstn), .c_load(c_load), .c_mode(c_mode), .c_data(c_data), .c_dout(c_dout),
    .locked(locked), .mon_err(mon_err), .range_err(range_err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .dir(dir)
`ifdef MOD12_MON_FIRST_ERR_EN
    , .first_exp(first_exp), .first_act(first_act), .first_vld(first_vld)
`endif
  );

  typedef struct {
    logic en, clr, rn, ld, md;
    logic [3:0] data, dout;
    logic l, e, r;
    logic [1:0] ec;
    logic [7:0] wc;
    logic d;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic en, clr, rn, ld, md, input logic [3:0] data, dout,
                     input logic l, e, r, input logic [1:0] ec, input logic [7:0] wc, input logic d);
    vec_t v;
    v.en = en; v.clr = clr; v.rn = rn; v.ld = ld; v.md = md; v.data = data; v.dout = dout;
    v.l = l; v.e = e; v.r = r; v.ec = ec; v.wc = wc; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, clr, rn, ld, md, input logic [3:0] data, dout);
    mon_en = en; mon_clr = clr; c_rstn = rn; c_load = ld; c_mode = md; c_data = data; c_dout = dout;
  endtask

  task automatic check(input string name, input logic l, e, r, input logic [1:0] ec,
                       input logic [7:0] wc, input logic d);
    checks++;
    if ({locked, mon_err, range_err, err_cnt, wrap_cnt, dir} === {l, e, r, ec, wc, d}) passed++;
    else $display("FAIL %s: got locked=%b err=%b rng=%b ecnt=%0d wcnt=%0d dir=%b, want %b %b %b %0d %0d %b",
                  name, locked, mon_err, range_err, err_cnt, wrap_cnt, dir, l, e, r, ec, wc, d);
  endtask

`ifdef MOD12_MON_FIRST_ERR_EN
  task automatic check_first(input string name, input logic [3:0] fe, fa, input logic fv);
    checks++;
    if ({first_exp, first_act, first_vld} === {fe, fa, fv}) passed++;
    else $display("FAIL %s: got exp=%0d act=%0d vld=%b, want %0d %0d %b",
                  name, first_exp, first_act, first_vld, fe, fa, fv);
  endtask
`endif

  initial begin
    // up sweep 0..11,0,1: wrap counted on the 11 sample
    for (int d = 0; d < 14; d++)
      add(1, 0, 1, 0, 0, 0, 4'(d % 12), 1, 0, 0, 0, (d >= 11) ? 8'd1 : 8'd0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // down sweep 3,2,1,0,11,10
    add(1, 0, 1, 0, 1, 0, 3,  1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 2,  1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 1, 0, 11, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0, 1, 1);
    // load and counter reset: no wrap, dir held
    add(1, 0, 1, 1, 0, 7, 9,  1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 7,  1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 2, 1);
    add(1, 0, 1, 1, 0, 4, 11, 1, 0, 0, 0, 2, 1);
    // single fault 4,5,9,10
    add(1, 0, 1, 0, 0, 0, 4,  1, 0, 0, 0, 2, 0);
    add(1, 0, 1, 0, 0, 0, 5,  1, 0, 0, 0, 2, 0);
    add(1, 0, 1, 0, 0, 0, 9,  1, 1, 0, 1, 2, 0);
    add(1, 0, 1, 0, 0, 0, 10, 1, 0, 0, 1, 2, 0);
    // saturation at 3 (ERR_W=2)
    add(1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 2, 2, 0);
    add(1, 0, 1, 0, 0, 0, 3,  1, 1, 0, 3, 2, 0);
    add(1, 0, 1, 0, 0, 0, 3,  1, 1, 0, 3, 2, 0);
    add(1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 3, 2, 0);
    add(1, 0, 1, 0, 0, 0, 5,  1, 1, 0, 3, 2, 0);
    // clear beats a coincident mismatch
    add(1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // out-of-range values: still predicted, 15 up -> 0
    add(1, 0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 14, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 15, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0);
    // re-entry: first sample not compared, next one is
    add(1, 0, 1, 0, 0, 0, 7,  1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 2,  1, 1, 0, 1, 0, 0);

    #12;
    check("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].rn, vecs[i].ld, vecs[i].md, vecs[i].data, vecs[i].dout);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].l, vecs[i].e, vecs[i].r, vecs[i].ec, vecs[i].wc, vecs[i].d);
`ifdef MOD12_MON_FIRST_ERR_EN
      if (i == 29 || i == 35) check_first($sformatf("first%0d", i), 6, 9, 1);
      if (i == 36) check_first("first_clr", 0, 0, 0);
      if (i == 43) check_first("first_again", 8, 2, 1);
`endif
    end

    // asynchronous reset mid-cycle
    drive(1, 0, 1, 0, 0, 0, 3);
    @(posedge clk);
    #1;
    check("pre_rst", 1, 0, 0, 1, 0, 0);
    #3 rstn = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rstn = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 9);
    @(posedge clk);
    #1;
    check("post_rst_idle", 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_err", 1, 1, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
